uart_tx_feeder: RTL

Buffered front end for the UART transmitter. It accepts words from the system-bus side at full clock rate into a small FIFO and drains them one at a time into the UART's `data_input`/`data_en` port, pacing on `tx_busy`. This decouples bus masters from the serial line rate so they can post bursts without stalling.

---
 rtl/uart_pkg.sv | 14 +
 rtl/uart_sync_fifo.sv | 89 ++++++++
 rtl/uart_tx_feeder.sv | 88 ++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART transmit feeder.
// The state encoding is fixed so it stays readable in waveforms and debug taps.
package uart_pkg;

    localparam int DEF_DATA_WIDTH = 25;
    localparam int DEF_DEPTH      = 8;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LOAD      = 2'd1,
        WAIT_DONE = 2'd2
    } tx_state_t;

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous circular-buffer FIFO with registered occupancy flags
// and a sticky overflow bit.
module uart_sync_fifo
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int DEPTH      = DEF_DEPTH,
    parameter int CNT_W      = $clog2(DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  wr_en,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  full,
    output logic                  empty,
    output logic [CNT_W-1:0]      count,
    output logic                  overflow
);

    localparam int PTR_W = $clog2(DEPTH);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("uart_sync_fifo: DEPTH must be a power of two >= 2");
    end

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [CNT_W-1:0]      r_count;
    logic [CNT_W-1:0]      w_count_nxt;
    logic                  r_full;
    logic                  r_empty;
    logic                  r_overflow;
    logic                  w_push;
    logic                  w_pop;

    // Full is judged on the registered count, so a same-cycle pop
    // never makes room for a write.
    assign w_push = wr_en && !r_full;
    assign w_pop  = pop && !r_empty;

    always_comb begin
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + 1'b1;
            2'b01:   w_count_nxt = r_count - 1'b1;
            default: w_count_nxt = r_count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_full     <= 1'b0;
            r_empty    <= 1'b1;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (wr_en && r_full) begin
                r_overflow <= 1'b1;
            end
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == CNT_W'(DEPTH));
            r_empty <= (w_count_nxt == '0);
        end
    end

    assign rd_data  = r_mem[r_rd_ptr];
    assign full     = r_full;
    assign empty    = r_empty;
    assign count    = r_count;
    assign overflow = r_overflow;

endmodule

// File: rtl/uart_tx_feeder.sv
// Buffers bus-side words and hands them to the UART one frame at a time,
// pacing on the transmitter's busy flag.
module uart_tx_feeder
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int DEPTH      = DEF_DEPTH,
    parameter int CNT_W      = $clog2(DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  wr_en,
    output logic                  full,
    output logic                  empty,
    output logic [CNT_W-1:0]      count,
    output logic                  overflow,
    output logic [DATA_WIDTH-1:0] uart_data,
    output logic                  uart_en,
    input  logic                  uart_busy
);

    tx_state_t             r_state;
    logic [DATA_WIDTH-1:0] r_uart_data;
    logic                  r_uart_en;
    logic [DATA_WIDTH-1:0] w_head;
    logic                  w_empty;
    logic                  w_pop;

    // The word leaves the FIFO only once the UART has acknowledged it
    // by raising busy, so exactly one frame is started per entry.
    assign w_pop = (r_state == LOAD) && uart_busy;

    uart_sync_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .CNT_W      (CNT_W)
    ) u_fifo (
        .clk      (clk),
        .rstn     (rstn),
        .wr_data  (wr_data),
        .wr_en    (wr_en),
        .pop      (w_pop),
        .rd_data  (w_head),
        .full     (full),
        .empty    (w_empty),
        .count    (count),
        .overflow (overflow)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= IDLE;
            r_uart_data <= '0;
            r_uart_en   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (!w_empty && !uart_busy) begin
                        r_state     <= LOAD;
                        r_uart_data <= w_head;
                        r_uart_en   <= 1'b1;
                    end
                end
                LOAD: begin
                    if (uart_busy) begin
                        r_state   <= WAIT_DONE;
                        r_uart_en <= 1'b0;
                    end
                end
                WAIT_DONE: begin
                    if (!uart_busy) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state   <= IDLE;
                    r_uart_en <= 1'b0;
                end
            endcase
        end
    end

    assign empty     = w_empty;
    assign uart_data = r_uart_data;
    assign uart_en   = r_uart_en;

endmodule
